// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- write-back stage of the five-stage LoongArch pipeline.
//
// Latches the memory-stage bus and commits it: general-register write,
// CSR read-data selection and CSR write, and exception / ERTN flush toward
// the earlier stages and the CSR file. Also drives the debug write-back
// trace and a retired-instruction counter. A busy trace sink (trace_hold)
// stalls retirement and back-pressures the memory stage.
//
// Ports
//   clk, resetn            pipeline clock, asynchronous active-low reset
//   ms_to_ws_valid/_bus    instruction handed over by the memory stage (168b)
//   ws_allowin             stage can take a new instruction this cycle
//   trace_hold             trace sink busy; hold the instruction in WS
//   ws_to_rf_bus           {rf_we, rf_waddr[4:0], rf_wdata[31:0]}
//   ws_forward             {result[31:0], dest[4:0], gr_we, valid} to decode
//   csr_re/_rnum/_rvalue   CSR read port (read data is combinational)
//   csr_we/_wnum/_wmask/_wdata  CSR write port
//   excp_flush, ertn_flush one-cycle commit pulses for exception / ERTN
//   wb_ecode, wb_esubcode  encoded exception cause (subcode always 0)
//   wb_pc                  PC of the committing instruction
//   retire_cnt             count of retired (non-excepting) instructions
//   debug_wb_*             write-back trace
// -----------------------------------------------------------------------------
module wb_stage (
  input  logic         clk,
  input  logic         resetn,
  input  logic         ms_to_ws_valid,
  input  logic [167:0] ms_to_ws_bus,
  output logic         ws_allowin,
  input  logic         trace_hold,
  output logic [37:0]  ws_to_rf_bus,
  output logic [38:0]  ws_forward,
  output logic         csr_re,
  output logic [13:0]  csr_rnum,
  input  logic [31:0]  csr_rvalue,
  output logic         csr_we,
  output logic [13:0]  csr_wnum,
  output logic [31:0]  csr_wmask,
  output logic [31:0]  csr_wdata,
  output logic         excp_flush,
  output logic         ertn_flush,
  output logic [5:0]   wb_ecode,
  output logic [8:0]   wb_esubcode,
  output logic [31:0]  wb_pc,
  output logic [31:0]  retire_cnt,
  output logic [31:0]  debug_wb_pc,
  output logic [3:0]   debug_wb_rf_we,
  output logic [4:0]   debug_wb_rf_wnum,
  output logic [31:0]  debug_wb_rf_wdata
);

  // Memory-stage bus layout, MSB first (pc sits in bits [31:0]).
  typedef struct packed {
    logic [31:0] csr_wdata;
    logic [31:0] csr_wmask;
    logic [13:0] csr_num;
    logic        csr_we;
    logic [15:0] excp_num;
    logic        excp;
    logic [31:0] final_result;
    logic        res_from_csr;
    logic        gr_we;
    logic [4:0]  dest;
    logic        op_ertn;
    logic [31:0] pc;
  } ms_bus_t;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;

  logic        ws_valid;
  ms_bus_t     ws_bus_r;
  logic [31:0] retire_cnt_r;

  logic        ws_ready_go;
  logic        commit;
  logic        ok;
  logic        flush;
  logic        rf_we;
  logic [31:0] wb_data;

  // ---------------------------------------------------------------------------
  // Stage handshake and commit qualifiers
  // ---------------------------------------------------------------------------
  assign ws_ready_go = !trace_hold;
  assign ws_allowin  = !ws_valid || ws_ready_go;
  assign commit      = ws_valid && ws_ready_go;
  assign ok          = commit && !ws_bus_r.excp;
  // An excepting instruction never raises ertn_flush, so the two pulses
  // are mutually exclusive by construction.
  assign excp_flush  = commit && ws_bus_r.excp;
  assign ertn_flush  = ok && ws_bus_r.op_ertn;
  assign flush       = excp_flush || ertn_flush;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid <= 1'b0;
    end else if (flush) begin
      // Flush wins over a simultaneous load: the stage drains for one cycle,
      // which keeps each flush a single-cycle pulse.
      ws_valid <= 1'b0;
    end else if (ws_allowin) begin
      ws_valid <= ms_to_ws_valid;
    end
  end

  // NOTE: the payload register is reset as well (not just the valid bit)
  // so that every pass-through output reads 0 straight out of reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_bus_r <= '0;
    end else if (ms_to_ws_valid && ws_allowin) begin
      ws_bus_r <= ms_to_ws_bus;
    end
  end

  // Wraps naturally at 2^32.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      retire_cnt_r <= '0;
    end else if (ok) begin
      retire_cnt_r <= retire_cnt_r + 32'd1;
    end
  end

  assign retire_cnt = retire_cnt_r;

  // ---------------------------------------------------------------------------
  // Result selection, register file and CSR ports
  // ---------------------------------------------------------------------------
  assign wb_data = ws_bus_r.res_from_csr ? csr_rvalue : ws_bus_r.final_result;

  assign csr_re   = ws_valid && ws_bus_r.res_from_csr;
  assign csr_rnum = ws_bus_r.csr_num;

  assign rf_we        = ok && ws_bus_r.gr_we;
  assign ws_to_rf_bus = {rf_we, ws_bus_r.dest, wb_data};

  assign csr_we    = ok && ws_bus_r.csr_we;
  assign csr_wnum  = ws_bus_r.csr_num;
  assign csr_wmask = ws_bus_r.csr_wmask;
  assign csr_wdata = ws_bus_r.csr_wdata;

  // gr_we is forwarded ungated: decode needs to see a pending writer even
  // while it is stalled by trace_hold.
  assign ws_forward = {wb_data, ws_bus_r.dest, ws_bus_r.gr_we, ws_valid};

  // ---------------------------------------------------------------------------
  // Exception cause encoding: lowest set excp_num bit wins
  // ---------------------------------------------------------------------------
  // NOTE: the output gets a default before the priority chain so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    wb_ecode = ECODE_INT;
    if      (ws_bus_r.excp_num[0]) wb_ecode = ECODE_INT;
    else if (ws_bus_r.excp_num[1]) wb_ecode = ECODE_ADEF;
    else if (ws_bus_r.excp_num[2]) wb_ecode = ECODE_ALE;
    else if (ws_bus_r.excp_num[3]) wb_ecode = ECODE_SYS;
    else if (ws_bus_r.excp_num[4]) wb_ecode = ECODE_BRK;
    else if (ws_bus_r.excp_num[5]) wb_ecode = ECODE_INE;
  end

  assign wb_esubcode = 9'd0;
  assign wb_pc       = ws_bus_r.pc;

  // ---------------------------------------------------------------------------
  // Debug write-back trace
  // ---------------------------------------------------------------------------
  assign debug_wb_pc       = ws_bus_r.pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = ws_bus_r.dest;
  assign debug_wb_rf_wdata = wb_data;

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage -- self-checking bench for wb_stage.
//
// A behavioural model holds "the instruction currently in WS" as a record,
// plus the retired count, and predicts every output from the stage rules.
// Directed scenarios cover the listed cases; a randomized phase then drives
// legal upstream traffic (stable bus while stalled, no valid during flush).
// Inputs change just after the falling edge; outputs are checked 1 time unit
// later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_wb_stage;

  typedef struct packed {
    logic [31:0] csr_wdata;
    logic [31:0] csr_wmask;
    logic [13:0] csr_num;
    logic        csr_we;
    logic [15:0] excp_num;
    logic        excp;
    logic [31:0] final_result;
    logic        res_from_csr;
    logic        gr_we;
    logic [4:0]  dest;
    logic        op_ertn;
    logic [31:0] pc;
  } instr_t;

  localparam logic [5:0] ECODES [6] = '{6'h00, 6'h08, 6'h09, 6'h0B, 6'h0C, 6'h0D};

  logic         clk = 1'b0;
  logic         resetn;
  logic         ms_to_ws_valid;
  logic [167:0] ms_to_ws_bus;
  logic         ws_allowin;
  logic         trace_hold;
  logic [37:0]  ws_to_rf_bus;
  logic [38:0]  ws_forward;
  logic         csr_re;
  logic [13:0]  csr_rnum;
  logic [31:0]  csr_rvalue;
  logic         csr_we;
  logic [13:0]  csr_wnum;
  logic [31:0]  csr_wmask;
  logic [31:0]  csr_wdata;
  logic         excp_flush;
  logic         ertn_flush;
  logic [5:0]   wb_ecode;
  logic [8:0]   wb_esubcode;
  logic [31:0]  wb_pc;
  logic [31:0]  retire_cnt;
  logic [31:0]  debug_wb_pc;
  logic [3:0]   debug_wb_rf_we;
  logic [4:0]   debug_wb_rf_wnum;
  logic [31:0]  debug_wb_rf_wdata;

  wb_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ws_allowin        (ws_allowin),
    .trace_hold        (trace_hold),
    .ws_to_rf_bus      (ws_to_rf_bus),
    .ws_forward        (ws_forward),
    .csr_re            (csr_re),
    .csr_rnum          (csr_rnum),
    .csr_rvalue        (csr_rvalue),
    .csr_we            (csr_we),
    .csr_wnum          (csr_wnum),
    .csr_wmask         (csr_wmask),
    .csr_wdata         (csr_wdata),
    .excp_flush        (excp_flush),
    .ertn_flush        (ertn_flush),
    .wb_ecode          (wb_ecode),
    .wb_esubcode       (wb_esubcode),
    .wb_pc             (wb_pc),
    .retire_cnt        (retire_cnt),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the instruction sitting in WS and the retired count.
  logic        m_valid;
  instr_t      m_ins;
  logic [31:0] m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] ref_ecode(input logic [15:0] num);
    for (int i = 0; i < 6; i++)
      if (num[i]) return ECODES[i];
    return 6'h00;
  endfunction

  // Compare every output against what the model says this cycle should show.
  task automatic check_outputs();
    logic        commit, ok;
    logic [31:0] data;
    commit = m_valid && !trace_hold;
    ok     = commit && !m_ins.excp;
    data   = m_ins.res_from_csr ? csr_rvalue : m_ins.final_result;
    check("allowin",    ws_allowin,       !m_valid || !trace_hold);
    check("rf_we",      ws_to_rf_bus[37], ok && m_ins.gr_we);
    check("dbg_we",     debug_wb_rf_we,   {4{ok && m_ins.gr_we}});
    check("csr_we",     csr_we,           ok && m_ins.csr_we);
    check("csr_re",     csr_re,           m_valid && m_ins.res_from_csr);
    check("excp_flush", excp_flush,       commit && m_ins.excp);
    check("ertn_flush", ertn_flush,       ok && m_ins.op_ertn);
    check("retire_cnt", retire_cnt,       m_cnt);
    check("fwd_valid",  ws_forward[0],    m_valid);
    check("esubcode",   wb_esubcode,      9'd0);
    if (m_valid) begin
      check("rf_bus",    ws_to_rf_bus[36:0], {m_ins.dest, data});
      check("forward",   ws_forward,         {data, m_ins.dest, m_ins.gr_we, 1'b1});
      check("csr_rnum",  csr_rnum,           m_ins.csr_num);
      check("csr_wnum",  csr_wnum,           m_ins.csr_num);
      check("csr_wmask", csr_wmask,          m_ins.csr_wmask);
      check("csr_wdata", csr_wdata,          m_ins.csr_wdata);
      check("wb_pc",     wb_pc,              m_ins.pc);
      check("ecode",     wb_ecode,           ref_ecode(m_ins.excp_num));
      check("dbg_pc",    debug_wb_pc,        m_ins.pc);
      check("dbg_wnum",  debug_wb_rf_wnum,   m_ins.dest);
      check("dbg_wdata", debug_wb_rf_wdata,  data);
    end
  endtask

  // Called just after a falling edge: apply inputs and check outputs.
  task automatic drive(input logic th, input logic v, input instr_t ins, input logic [31:0] rv);
    trace_hold     = th;
    ms_to_ws_valid = v;
    ms_to_ws_bus   = ins;
    csr_rvalue     = rv;
    #1;
    check_outputs();
  endtask

  // Cross one rising edge and move the model on by the stage rules.
  task automatic advance();
    logic commit, ok, flush, allow, load;
    commit = m_valid && !trace_hold;
    ok     = commit && !m_ins.excp;
    flush  = commit && (m_ins.excp || m_ins.op_ertn);
    allow  = !m_valid || !trace_hold;
    load   = ms_to_ws_valid && allow;
    @(posedge clk);
    if (ok) m_cnt = m_cnt + 32'd1;
    if (flush)      m_valid = 1'b0;
    else if (allow) m_valid = ms_to_ws_valid;
    if (load) m_ins = instr_t'(ms_to_ws_bus);
    @(negedge clk);
  endtask

  function automatic instr_t rand_instr();
    instr_t r;
    r.pc           = $urandom & 32'hFFFF_FFFC;
    r.op_ertn      = ($urandom_range(0, 4) == 0);
    r.dest         = 5'($urandom);
    r.gr_we        = 1'($urandom);
    r.res_from_csr = 1'($urandom);
    r.final_result = $urandom;
    r.excp         = ($urandom_range(0, 4) == 0);
    case ($urandom_range(0, 2))
      0:       r.excp_num = 16'($urandom);
      1:       r.excp_num = 16'($urandom) & 16'hFFC0;
      default: r.excp_num = 16'(1 << $urandom_range(0, 15));
    endcase
    r.csr_we    = 1'($urandom);
    r.csr_num   = 14'($urandom);
    r.csr_wmask = $urandom;
    r.csr_wdata = $urandom;
    return r;
  endfunction

  task automatic reset_model();
    m_valid = 1'b0;
    m_ins   = '0;
    m_cnt   = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    instr_t a, b, z;
    logic th, v, allow, flush;
    z = '0;

    // ---------------- reset state ----------------
    resetn         = 1'b0;
    trace_hold     = 1'b0;
    ms_to_ws_valid = 1'b0;
    ms_to_ws_bus   = '0;
    csr_rvalue     = '0;
    reset_model();
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    check("rst_allowin", ws_allowin, 1'b1);
    check("rst_rf_bus",  ws_to_rf_bus, 38'd0);
    check("rst_forward", ws_forward, 39'd0);
    check("rst_pc",      debug_wb_pc, 32'd0);
    resetn = 1'b1;

    // ---------------- back-to-back commits ----------------
    a = '0; a.pc = 32'h1C00_0000; a.gr_we = 1'b1; a.dest = 5'd5; a.final_result = 32'h1234_5678;
    b = '0; b.pc = 32'h1C00_0004; b.gr_we = 1'b1; b.dest = 5'd6; b.final_result = 32'hA5A5_A5A5;
    drive(1'b0, 1'b1, a, 32'h0); advance();
    drive(1'b0, 1'b1, b, 32'h0);
    check("b2b_rf_1",  ws_to_rf_bus, {1'b1, 5'd5, 32'h1234_5678});
    check("b2b_dbg_we", debug_wb_rf_we, 4'hF);
    advance();
    drive(1'b0, 1'b0, z, 32'h0);
    check("b2b_rf_2",  ws_to_rf_bus, {1'b1, 5'd6, 32'hA5A5_A5A5});
    check("b2b_pc_2",  debug_wb_pc, 32'h1C00_0004);
    advance();

    // ---------------- CSR read and write ----------------
    a = '0; a.res_from_csr = 1'b1; a.csr_num = 14'h005; a.dest = 5'd7; a.gr_we = 1'b1;
    a.csr_we = 1'b1; a.csr_wmask = 32'h0000_FFFF; a.csr_wdata = 32'h0000_BEEF;
    a.final_result = 32'h1111_2222; a.pc = 32'h1C00_0008;
    drive(1'b0, 1'b1, a, 32'h0);
    check("b2b_retire", retire_cnt, 32'd2);
    advance();
    drive(1'b0, 1'b0, z, 32'hDEAD_0000);
    check("csr_rnum_d",  csr_rnum, 14'h005);
    check("csr_rf",      ws_to_rf_bus, {1'b1, 5'd7, 32'hDEAD_0000});
    check("csr_we_d",    csr_we, 1'b1);
    check("csr_wnum_d",  csr_wnum, 14'h005);
    check("csr_wmask_d", csr_wmask, 32'h0000_FFFF);
    check("csr_wdata_d", csr_wdata, 32'h0000_BEEF);
    advance();

    // ---------------- exception ----------------
    a = '0; a.excp = 1'b1; a.excp_num = 16'h0018; a.gr_we = 1'b1; a.dest = 5'd3;
    a.csr_we = 1'b1; a.pc = 32'h1C00_000C;
    drive(1'b0, 1'b1, a, 32'h0); advance();
    drive(1'b0, 1'b0, z, 32'h0);
    check("exc_flush", excp_flush, 1'b1);
    check("exc_ecode", wb_ecode, 6'h0B);
    check("exc_rf_we", ws_to_rf_bus[37], 1'b0);
    check("exc_ertn",  ertn_flush, 1'b0);
    advance();
    drive(1'b0, 1'b0, z, 32'h0);
    check("exc_pulse",  excp_flush, 1'b0);
    check("exc_drain",  ws_forward[0], 1'b0);
    check("exc_retire", retire_cnt, 32'd3);
    advance();

    // ---------------- ERTN ----------------
    a = '0; a.op_ertn = 1'b1; a.pc = 32'h1C00_0010;
    drive(1'b0, 1'b1, a, 32'h0); advance();
    drive(1'b0, 1'b0, z, 32'h0);
    check("ertn_flush_d", ertn_flush, 1'b1);
    check("ertn_excp",    excp_flush, 1'b0);
    advance();
    drive(1'b0, 1'b0, z, 32'h0);
    check("ertn_pulse",  ertn_flush, 1'b0);
    check("ertn_retire", retire_cnt, 32'd4);
    advance();

    // ---------------- trace hold ----------------
    a = '0; a.gr_we = 1'b1; a.dest = 5'd9; a.final_result = 32'h0000_0099; a.pc = 32'h1C00_0014;
    drive(1'b0, 1'b1, a, 32'h0); advance();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, a, 32'h0);
      check("hold_allowin", ws_allowin, 1'b0);
      check("hold_rf_we",   ws_to_rf_bus[37], 1'b0);
      advance();
    end
    drive(1'b0, 1'b0, z, 32'h0);
    check("hold_commit", ws_to_rf_bus, {1'b1, 5'd9, 32'h0000_0099});
    advance();
    drive(1'b0, 1'b0, z, 32'h0);
    check("hold_no_dup", ws_to_rf_bus[37], 1'b0);
    check("hold_retire", retire_cnt, 32'd5);
    advance();

    // ---------------- reset mid-operation ----------------
    drive(1'b0, 1'b1, a, 32'h0); advance();
    drive(1'b1, 1'b1, a, 32'h0);
    #1;
    resetn = 1'b0;
    #1;
    reset_model();
    check_outputs();
    check("mrst_allowin", ws_allowin, 1'b1);
    check("mrst_retire",  retire_cnt, 32'd0);
    check("mrst_rf_we",   ws_to_rf_bus[37], 1'b0);
    check("mrst_pc",      wb_pc, 32'd0);
    @(negedge clk);
    trace_hold     = 1'b0;
    ms_to_ws_valid = 1'b0;
    ms_to_ws_bus   = '0;
    resetn         = 1'b1;

    // ---------------- randomized legal traffic ----------------
    v = 1'b0;
    a = '0;
    for (int n = 0; n < 3000; n++) begin
      th    = ($urandom_range(0, 3) == 0);
      allow = !m_valid || !th;
      flush = m_valid && !th && (m_ins.excp || m_ins.op_ertn);
      if (allow) begin
        a = rand_instr();
        v = flush ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
      drive(th, v, a, $urandom);
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage LoongArch pipeline, directly downstream of the memory stage. It latches the memory-stage bus and commits results:
- general-register write;
- CSR read-data selection and CSR write;
- exception / ERTN flush generation toward all earlier stages and the CSR file.

It also drives the debug write-back trace and a retired-instruction counter, and can back-pressure the memory stage through a trace hold input.

## Interface
- No parameters; bus widths are fixed: MS_TO_WS_BUS_WD = 168, WS_TO_RF_BUS_WD = 38, WS_FORWARD_WD = 39.
- clk  in  1  pipeline clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- ms_to_ws_valid  in  1  memory stage has an instruction
- ms_to_ws_bus  in  168  bus from the memory stage; field layout in Operation
- ws_allowin  out  1  stage may accept a new instruction this cycle
- trace_hold  in  1  debug trace sink busy; stall retirement
- ws_to_rf_bus  out  38  {rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}
- ws_forward  out  39  {valid[0], gr_we[1], dest[6:2], result[38:7]} to decode
- csr_re  out  1  CSR read enable
- csr_rnum  out  14  CSR read number
- csr_rvalue  in  32  combinational CSR read data
- csr_we  out  1  CSR write enable
- csr_wnum  out  14  CSR write number
- csr_wmask  out  32  CSR write mask
- csr_wdata  out  32  CSR write data
- excp_flush  out  1  exception commit
- ertn_flush  out  1  ERTN commit
- wb_ecode  out  6  encoded exception code
- wb_esubcode  out  9  exception subcode, always 0
- wb_pc  out  32  PC of the committing instruction
- retire_cnt  out  32  retired-instruction count
- debug_wb_pc  out  32  trace PC
- debug_wb_rf_we  out  4  trace write-enable strobe, all four bits equal
- debug_wb_rf_wnum  out  5  trace destination register
- debug_wb_rf_wdata  out  32  trace write data

## Operation
- ms_to_ws_bus field layout:

  | Bits | Field |
  |---|---|
  | [31:0] | pc |
  | [32] | op_ertn |
  | [37:33] | dest |
  | [38] | gr_we |
  | [39] | res_from_csr |
  | [71:40] | final_result |
  | [72] | excp |
  | [88:73] | excp_num |
  | [89] | csr_we |
  | [103:90] | csr_num |
  | [135:104] | csr_wmask |
  | [167:136] | csr_wdata |

- State registers:
  - ws_valid;
  - ws_bus_r (168 bits), loaded when ms_to_ws_valid && ws_allowin;
  - retire_cnt.
- Stage control:
  - ws_ready_go = !trace_hold.
  - ws_allowin = !ws_valid || ws_ready_go.
- commit = ws_valid && ws_ready_go.
- ok = commit && !excp.
- Result selection: wb_data = res_from_csr ? csr_rvalue : final_result.
- CSR read:
  - csr_re = ws_valid && res_from_csr.
  - csr_rnum = csr_num.
- General-register write:
  - rf_we = ok && gr_we.
  - rf_waddr = dest.
  - rf_wdata = wb_data.
- CSR write:
  - csr_we (out) = ok && bus csr_we.
  - csr_wnum, csr_wmask and csr_wdata are passed through from the bus.
- Flush outputs:
  - excp_flush = commit && excp.
  - ertn_flush = ok && op_ertn.
  - Both are never high together.
- wb_pc = pc.
- wb_ecode comes from a priority encoder over excp_num, lowest set bit wins:

  | excp_num bit | Exception | wb_ecode |
  |---|---|---|
  | 0 | INT | 0x00 |
  | 1 | ADEF | 0x08 |
  | 2 | ALE | 0x09 |
  | 3 | SYS | 0x0B |
  | 4 | BRK | 0x0C |
  | 5 | INE | 0x0D |

  - No bit set, or only bits 15:6 set, gives 0x00.
- Debug trace:
  - debug_wb_pc = pc.
  - debug_wb_rf_we = {4{rf_we}}.
  - debug_wb_rf_wnum = dest.
  - debug_wb_rf_wdata = wb_data.
- ws_forward = {wb_data, dest, gr_we, ws_valid}.
  - Decode uses it for the CSR-read interlock and for forwarding.
- retire_cnt increments by 1 on every cycle with ok, including ERTN. It wraps 0xFFFFFFFF -> 0.

## Timing
- Reset (resetn low, asynchronous):
  - ws_valid = 0, ws_bus_r = 0, retire_cnt = 0.
  - Consequently all enables and flushes are 0, ws_allowin = 1, and the other outputs are 0.
- Latency: an instruction accepted at edge N commits combinationally in cycle N (after the edge) if trace_hold is low.
- Flush:
  - On the edge following a cycle with excp_flush or ertn_flush, ws_valid <= 0. This overrides any simultaneous load, so each flush is exactly a one-cycle pulse.
  - The upstream stage keeps ms_to_ws_valid low during a flush.
- trace_hold:
  - While high, the instruction stays in WS, ws_allowin = 0, and no rf, CSR, flush or counter effects occur.
  - The commit happens in the first cycle trace_hold is low.
  - Upstream must hold its bus stable while ws_allowin = 0.
- Excepting instruction: rf_we = 0, csr_we = 0, ertn_flush = 0, retire_cnt unchanged.
- Empty stage (ws_valid = 0): all write enables, flushes and the trace strobe are 0, whatever the stale bus contents.
- Back-to-back: with trace_hold low, one instruction commits every cycle with no bubbles.

## Test plan
- Back-to-back commits: reset, then two instructions on consecutive cycles:
  - first: pc = 0x1C000000, gr_we = 1, dest = 5, final_result = 0x12345678;
  - second: pc = 0x1C000004, dest = 6, final_result = 0xA5A5A5A5.
  - Required: rf writes (5, 0x12345678) then (6, 0xA5A5A5A5) on consecutive cycles, debug_wb_rf_we = 4'hF, retire_cnt = 2.
- CSR read and write: res_from_csr = 1, csr_num = 0x005, csr_rvalue = 0xDEAD0000, dest = 7, csr_we = 1, csr_wmask = 0xFFFF, csr_wdata = 0x0000BEEF.
  - Required: csr_rnum = 0x005, rf write (7, 0xDEAD0000), csr_wnum = 0x005 with the given mask and data, all in the same cycle.
- Exception: excp = 1, excp_num = 16'h0018, gr_we = 1.
  - Required: excp_flush high for exactly one cycle, wb_ecode = 0x0B, rf_we = 0, retire_cnt unchanged, ws_valid = 0 on the next cycle.
- ERTN: op_ertn = 1, excp = 0.
  - Required: ertn_flush pulses for one cycle, excp_flush = 0, retire_cnt increments.
- Trace hold: assert trace_hold for 3 cycles while a valid write to r9 sits in WS.
  - Required: ws_allowin = 0 and rf_we = 0 for those 3 cycles, then a single rf write to r9, no duplicate.
- Reset mid-operation: drop resetn while a valid instruction is held by trace_hold.
  - Required: outputs clear immediately with no clock edge, retire_cnt = 0, ws_allowin = 1.
